// File: rtl/reg_seq_pkg.sv
// reg_seq_pkg: shared definitions for the register-file sequencer.
//   state_t      - sequencer states IDLE -> READ -> CAPT -> EXEC -> WRITE
//   W_DEF        - default data width (register file width)
//   AW_DEF       - default register address width (4 registers)
//   TIMEOUT_DEF  - default EXEC wait limit used by the optional watchdog
package reg_seq_pkg;

    localparam int W_DEF       = 8;
    localparam int AW_DEF      = 2;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CAPT  = 3'd2,
        EXEC  = 3'd3,
        WRITE = 3'd4
    } state_t;

endpackage

// File: rtl/reg_seq_wdog.sv
// reg_seq_wdog: EXEC-phase watchdog for reg_seq_ctrl.
// Built only when REG_SEQ_TIMEOUT_EN is defined.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load      - reload the counter with TIMEOUT (asserted the cycle before EXEC)
//   active    - sequencer is in EXEC
//   hit       - ALU result valid this cycle (no decrement)
//   expire    - this EXEC cycle is the last allowed one
module reg_seq_wdog
    import reg_seq_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic active,
    input  logic hit,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(TIMEOUT);
        end else if (active && !hit && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is flagged in the EXEC cycle whose decrement would reach zero,
    // so the sequencer spends exactly TIMEOUT cycles in EXEC.
    assign expire = active && (cnt_q == CW'(1));

endmodule

// File: rtl/reg_seq_ctrl.sv
// reg_seq_ctrl: sequencer driving the 4x8 register file read/write ports and
// an ALU. One operation at a time: read A/B, capture operands, wait for the
// ALU result, write it back for one cycle (if op_wb), pulse done.
// Optional feature macro: REG_SEQ_TIMEOUT_EN (EXEC watchdog, err pulse).
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   op_valid/op_ready              - operation handshake (ready only in IDLE)
//   op_dir_a/op_dir_b/op_dir_wr    - source A/B and destination registers
//   op_wb                          - 1 = write result back
//   DIR_A/DIR_B/DIR_WR/EN/DI       - register file address/enable/data
//   DOA/DOB                        - register file read data (registered)
//   alu_a/alu_b/alu_valid          - operands to the ALU
//   alu_res/alu_res_valid          - ALU result
//   done                           - one-cycle pulse, operation retired
//   err                            - one-cycle pulse, ALU timeout
module reg_seq_ctrl
    import reg_seq_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int AW      = AW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [AW-1:0] op_dir_a,
    input  logic [AW-1:0] op_dir_b,
    input  logic [AW-1:0] op_dir_wr,
    input  logic          op_wb,
    output logic [AW-1:0] DIR_A,
    output logic [AW-1:0] DIR_B,
    output logic [AW-1:0] DIR_WR,
    output logic          EN,
    output logic [W-1:0]  DI,
    input  logic [W-1:0]  DOA,
    input  logic [W-1:0]  DOB,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic          alu_valid,
    input  logic [W-1:0]  alu_res,
    input  logic          alu_res_valid,
    output logic          done,
    output logic          err
);

    state_t        state_q, state_d;
    logic [AW-1:0] dir_a_q, dir_a_d;
    logic [AW-1:0] dir_b_q, dir_b_d;
    logic [AW-1:0] dir_wr_q, dir_wr_d;
    logic          wb_q, wb_d;
    logic [W-1:0]  alu_a_q, alu_a_d;
    logic [W-1:0]  alu_b_q, alu_b_d;
    logic [W-1:0]  di_q, di_d;
    logic          err_q, err_d;
    logic          expire;

`ifdef REG_SEQ_TIMEOUT_EN
    logic wdog_load;
    logic wdog_active;

    assign wdog_load   = (state_q == CAPT);
    assign wdog_active = (state_q == EXEC);

    reg_seq_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .load   (wdog_load),
        .active (wdog_active),
        .hit    (alu_res_valid),
        .expire (expire)
    );
`else
    logic unused_timeout;

    assign expire         = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        state_d  = state_q;
        dir_a_d  = dir_a_q;
        dir_b_d  = dir_b_q;
        dir_wr_d = dir_wr_q;
        wb_d     = wb_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        di_d     = di_q;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    dir_a_d  = op_dir_a;
                    dir_b_d  = op_dir_b;
                    dir_wr_d = op_dir_wr;
                    wb_d     = op_wb;
                    state_d  = READ;
                end
            end
            READ: begin
                state_d = CAPT;
            end
            CAPT: begin
                // Register file output is valid here, one cycle after READ.
                alu_a_d = DOA;
                alu_b_d = DOB;
                state_d = EXEC;
            end
            EXEC: begin
                // A result arriving in the expiry cycle still retires normally.
                if (alu_res_valid) begin
                    di_d    = alu_res;
                    state_d = WRITE;
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            dir_a_q  <= '0;
            dir_b_q  <= '0;
            dir_wr_q <= '0;
            wb_q     <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            di_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_a_q  <= dir_a_d;
            dir_b_q  <= dir_b_d;
            dir_wr_q <= dir_wr_d;
            wb_q     <= wb_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            di_q     <= di_d;
            err_q    <= err_d;
        end
    end

    // Strobes decode directly from the state flop so reset clears EN at once.
    assign op_ready  = (state_q == IDLE);
    assign alu_valid = (state_q == EXEC);
    assign done      = (state_q == WRITE);
    assign EN        = (state_q == WRITE) && wb_q;
    assign err       = err_q;

    assign DIR_A  = dir_a_q;
    assign DIR_B  = dir_b_q;
    assign DIR_WR = dir_wr_q;
    assign DI     = di_q;
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Testbench for reg_seq_ctrl with a behavioural 4x8 register file and ALU.
module tb_reg_seq_ctrl;

    localparam int W  = 8;
    localparam int AW = 2;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [AW-1:0] op_dir_a = '0;
    logic [AW-1:0] op_dir_b = '0;
    logic [AW-1:0] op_dir_wr = '0;
    logic          op_wb = 1'b0;
    logic [AW-1:0] DIR_A, DIR_B, DIR_WR;
    logic          EN;
    logic [W-1:0]  DI;
    logic [W-1:0]  DOA = '0;
    logic [W-1:0]  DOB = '0;
    logic [W-1:0]  alu_a, alu_b;
    logic          alu_valid;
    logic [W-1:0]  alu_res = '0;
    logic          alu_res_valid = 1'b0;
    logic          done;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;
    int en_cnt = 0;
    int done_cnt = 0;

    // Register file contents and the bench's expected view of them.
    logic [W-1:0] rf  [4] = '{default: '0};
    logic [W-1:0] mdl [4] = '{default: '0};

    always #5 clk = ~clk;

    reg_seq_ctrl #(
        .W       (W),
        .AW      (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_dir_a      (op_dir_a),
        .op_dir_b      (op_dir_b),
        .op_dir_wr     (op_dir_wr),
        .op_wb         (op_wb),
        .DIR_A         (DIR_A),
        .DIR_B         (DIR_B),
        .DIR_WR        (DIR_WR),
        .EN            (EN),
        .DI            (DI),
        .DOA           (DOA),
        .DOB           (DOB),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_valid     (alu_valid),
        .alu_res       (alu_res),
        .alu_res_valid (alu_res_valid),
        .done          (done),
        .err           (err)
    );

    // Register file: registered reads, write when EN.
    always @(posedge clk) begin
        DOA <= rf[DIR_A];
        DOB <= rf[DIR_B];
        if (EN) rf[DIR_WR] <= DI;
    end

    always @(negedge clk) begin
        if (EN)   en_cnt   = en_cnt + 1;
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic junk_fields();
        op_dir_a  = AW'($urandom);
        op_dir_b  = AW'($urandom);
        op_dir_wr = AW'($urandom);
        op_wb     = 1'($urandom);
    endtask

    // Present an op at a negedge in IDLE; return at the first EXEC negedge.
    task automatic start_op(input logic [AW-1:0] a, input logic [AW-1:0] b,
                            input logic [AW-1:0] wr, input logic wb, input logic hold);
        chk("ready_idle", op_ready, 1);
        op_valid  = 1'b1;
        op_dir_a  = a;
        op_dir_b  = b;
        op_dir_wr = wr;
        op_wb     = wb;
        @(negedge clk);
        // READ: further requests and stray ALU results must be ignored
        op_valid      = hold;
        junk_fields();
        alu_res_valid = 1'($urandom);
        alu_res       = W'($urandom);
        chk("ready_read", op_ready, 0);
        chk("dir_a", DIR_A, 32'(a));
        chk("dir_b", DIR_B, 32'(b));
        chk("en_read", EN, 0);
        chk("aluv_read", alu_valid, 0);
        @(negedge clk);
        // CAPT
        alu_res_valid = 1'($urandom);
        junk_fields();
        chk("ready_capt", op_ready, 0);
        chk("en_capt", EN, 0);
        chk("aluv_capt", alu_valid, 0);
        @(negedge clk);
        alu_res_valid = 1'b0;
    endtask

    task automatic do_op(input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] wr, input logic wb,
                         input logic [W-1:0] res, input int dly, input logic hold);
        int en0;
        int done0;
        start_op(a, b, wr, wb, hold);
        en0   = en_cnt;
        done0 = done_cnt;
        for (int k = 0; k <= dly; k++) begin
            chk("aluv_exec", alu_valid, 1);
            chk("alu_a", alu_a, 32'(mdl[a]));
            chk("alu_b", alu_b, 32'(mdl[b]));
            chk("ready_exec", op_ready, 0);
            chk("en_exec", EN, 0);
            chk("done_exec", done, 0);
            if (k == dly) begin
                alu_res_valid = 1'b1;
                alu_res       = res;
            end
            @(negedge clk);
        end
        alu_res_valid = 1'b0;
        alu_res       = W'($urandom);
        // WRITE
        chk("done_wr", done, 1);
        chk("en_wr", EN, 32'(wb));
        chk("dir_wr", DIR_WR, 32'(wr));
        chk("di", DI, 32'(res));
        chk("aluv_wr", alu_valid, 0);
        chk("ready_wr", op_ready, 0);
        chk("err_wr", err, 0);
        @(negedge clk);
        chk("ready_back", op_ready, 1);
        chk("done_back", done, 0);
        chk("en_back", EN, 0);
        chk("en_pulses", 32'(en_cnt - en0), 32'(wb));
        chk("done_pulses", 32'(done_cnt - done0), 1);
        if (wb) mdl[wr] = res;
        op_valid = hold;
    endtask

    initial begin
        int dly_max;
`ifdef REG_SEQ_TIMEOUT_EN
        dly_max = TO - 1;
`else
        dly_max = 5;
`endif
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", op_ready, 1);
        chk("rst_en", EN, 0);
        chk("rst_done", done, 0);
        chk("rst_aluv", alu_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_dirs", {DIR_A, DIR_B, DIR_WR}, 0);
        chk("rst_di", DI, 0);
        chk("rst_alu_ab", {alu_a, alu_b}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", op_ready, 1);

        // x1 = 5A, then read it back as operand A
        do_op(2'd0, 2'd0, 2'd1, 1'b1, 8'h5A, 0, 1'b0);
        do_op(2'd1, 2'd0, 2'd0, 1'b0, 8'h11, 0, 1'b0);
        chk("x1_val", rf[1], 8'h5A);

        // Back-to-back with op_valid held; second op reads x2 written by first
        do_op(2'd0, 2'd0, 2'd2, 1'b1, 8'h33, 0, 1'b1);
        chk("b2b_alu_a_src", mdl[2], 8'h33);
        do_op(2'd2, 2'd1, 2'd3, 1'b0, 8'hFF, 0, 1'b0);
        chk("x3_unchanged", rf[3], 8'h00);
        chk("x2_val", rf[2], 8'h33);

        // Slow ALU response
`ifndef REG_SEQ_TIMEOUT_EN
        do_op(2'd1, 2'd2, 2'd0, 1'b1, 8'hC3, 7, 1'b0);
`endif

        // Reset during EXEC: op lost, no write, no done
        begin
            int en0;
            int done0;
            en0   = en_cnt;
            done0 = done_cnt;
            start_op(2'd1, 2'd2, 2'd3, 1'b1, 1'b0);
            op_valid = 1'b0;
            chk("pre_rst_aluv", alu_valid, 1);
            rst = 1'b1;
            #1;
            chk("midrst_ready", op_ready, 1);
            chk("midrst_en", EN, 0);
            chk("midrst_aluv", alu_valid, 0);
            chk("midrst_alu_a", alu_a, 0);
            @(negedge clk);
            rst = 1'b0;
            alu_res_valid = 1'b1;
            @(negedge clk);
            alu_res_valid = 1'b0;
            chk("midrst_idle", op_ready, 1);
            chk("midrst_en_cnt", 32'(en_cnt - en0), 0);
            chk("midrst_done_cnt", 32'(done_cnt - done0), 0);
            chk("x3_after_rst", rf[3], 32'(mdl[3]));
        end

`ifdef REG_SEQ_TIMEOUT_EN
        // No ALU response: err after TO EXEC cycles, no write, no done
        begin
            int en0;
            int done0;
            en0   = en_cnt;
            done0 = done_cnt;
            start_op(2'd0, 2'd1, 2'd2, 1'b1, 1'b0);
            op_valid = 1'b0;
            for (int k = 0; k < TO; k++) begin
                chk("to_aluv", alu_valid, 1);
                chk("to_err_early", err, 0);
                @(negedge clk);
            end
            chk("to_err", err, 1);
            chk("to_aluv_drop", alu_valid, 0);
            chk("to_ready", op_ready, 1);
            @(negedge clk);
            chk("to_err_pulse", err, 0);
            chk("to_en_cnt", 32'(en_cnt - en0), 0);
            chk("to_done_cnt", 32'(done_cnt - done0), 0);
        end
        // Result in the expiry cycle still retires
        do_op(2'd3, 2'd0, 2'd1, 1'b1, 8'h77, TO - 1, 1'b0);
`else
        chk("err_tied", err, 0);
`endif

        // Randomized operations against the model
        for (int n = 0; n < 24; n++) begin
            logic hold;
            hold = (n == 23) ? 1'b0 : 1'($urandom);
            do_op(AW'($urandom), AW'($urandom), AW'($urandom), 1'($urandom),
                  W'($urandom), int'($urandom_range(dly_max, 0)), hold);
            if (!hold) begin
                repeat ($urandom_range(2, 0)) begin
                    op_valid = 1'b0;
                    @(negedge clk);
                    chk("gap_ready", op_ready, 1);
                end
            end
        end
        op_valid = 1'b0;
        for (int r = 0; r < 4; r++) chk("rf_final", rf[r], 32'(mdl[r]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
